// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//
// Upstream feeder for the 32-bit Intermediate_Register stage. Keeps the
// program counter, fetches one word per request over a req/ack memory
// handshake and presents it on instr_out with a single-cycle ir_enable
// strobe that drives the register's enable input directly. Supports a
// downstream stall and PC redirects (branch/jump).
//
// Ports:
//   clk            clock, all logic on the rising edge
//   rst            synchronous active-high reset
//   stall          downstream not ready; holds the delivered word
//   redirect_valid load redirect_pc as the next fetch address
//   redirect_pc    redirect target, bits [1:0] are ignored
//   mem_req        memory request valid
//   mem_addr       word-aligned request address
//   mem_ack        memory accepts the request; mem_rdata valid this cycle
//   mem_rdata      fetched word
//   instr_out      word for the Intermediate_Register data input
//   ir_enable      load strobe for the Intermediate_Register
//   pc_out         address of the word on instr_out
//   busy           high whenever the unit is not idle

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_out,
    output logic        ir_enable,
    output logic [31:0] pc_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DELIVER
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] instr_buf_q, instr_buf_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        kill_q, kill_d;
    logic [31:0] redirect_aligned;

    // Masking keeps every redirect target word aligned.
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    // State register; reset also abandons any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            kill_q      <= 1'b0;
            instr_buf_q <= 32'h0;
            pc_out_q    <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            kill_q      <= kill_d;
            instr_buf_q <= instr_buf_d;
            pc_out_q    <= pc_out_d;
        end
    end

    // Next-state logic. A request address must stay stable until acked, so a
    // redirect during an unacked request only arms kill; the stale data is
    // dropped when its ack finally arrives and the refetch uses pc.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        kill_d      = kill_q;
        instr_buf_d = instr_buf_q;
        pc_out_d    = pc_out_q;
        case (state_q)
            IDLE: begin
                state_d    = REQ;
                req_addr_d = redirect_valid ? redirect_aligned : pc_q;
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_aligned;
                    if (mem_ack) begin
                        req_addr_d = redirect_aligned;
                        kill_d     = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (mem_ack) begin
                    if (kill_q) begin
                        kill_d     = 1'b0;
                        req_addr_d = pc_q;
                    end else begin
                        instr_buf_d = mem_rdata;
                        pc_out_d    = req_addr_q;
                        state_d     = DELIVER;
                    end
                end
            end
            DELIVER: begin
                if (redirect_valid) begin
                    pc_d       = redirect_aligned;
                    req_addr_d = redirect_aligned;
                    state_d    = REQ;
                end else if (!stall) begin
                    pc_d       = pc_out_q + PC_STEP;
                    req_addr_d = pc_out_q + PC_STEP;
                    state_d    = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs; a redirect in DELIVER drops the word, so it suppresses ir_enable.
    always_comb begin
        mem_req   = (state_q == REQ);
        mem_addr  = req_addr_q;
        instr_out = instr_buf_q;
        pc_out    = pc_out_q;
        ir_enable = (state_q == DELIVER) && !stall && !redirect_valid;
        busy      = (state_q != IDLE);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. Directed scenarios pin the
// reference model with hand-computed values, then a long randomized run
// compares every output against the model on every cycle. A second instance
// with RESET_PC=32'hFFFF_FFF8 checks address wrap-around.

module tb_instr_fetch_unit;

    localparam logic [31:0] DATA_KEY = 32'hA5A5_0000;
    localparam logic [31:0] MODEL_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_ack;

    logic        mem_req, ir_enable, busy;
    logic [31:0] mem_addr, mem_rdata, instr_out, pc_out;

    logic        mem_req2, ir_enable2, busy2;
    logic [31:0] mem_addr2, mem_rdata2, instr_out2, pc_out2;

    int checksTotal = 0;
    int checksPassed = 0;

    // Reference model: what the fetch unit is doing, in transaction terms.
    bit          modelValid = 0;
    bit          mBusy;
    bit          mReq;
    bit          mHeld;
    bit          mDoomed;
    logic [31:0] mAddr;
    logic [31:0] mResume;
    logic [31:0] mWord;
    logic [31:0] mPc;

    // Per-cycle snapshots of the current directed scenario.
    int          cyc;
    bit          snapReq [0:63];
    bit          snapIr  [0:63];
    bit          snapIr2 [0:63];
    logic [31:0] snapAddr  [0:63];
    logic [31:0] snapAddr2 [0:63];
    logic [31:0] snapPc    [0:63];
    logic [31:0] snapPc2   [0:63];
    logic [31:0] snapInstr [0:63];

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(32'd4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .instr_out(instr_out), .ir_enable(ir_enable),
        .pc_out(pc_out), .busy(busy)
    );

    instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(32'd4)) dutWrap (
        .clk(clk), .rst(rst), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req(mem_req2), .mem_addr(mem_addr2), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata2), .instr_out(instr_out2), .ir_enable(ir_enable2),
        .pc_out(pc_out2), .busy(busy2)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a failure line when it misses.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic compareModel();
        checkOutput("busy", {31'b0, busy}, {31'b0, mBusy});
        checkOutput("mem_req", {31'b0, mem_req}, {31'b0, mReq});
        if (mReq) checkOutput("mem_addr", mem_addr, mAddr);
        checkOutput("instr_out", instr_out, mWord);
        checkOutput("pc_out", pc_out, mPc);
        checkOutput("ir_enable", {31'b0, ir_enable},
                    {31'b0, mHeld && !stall && !redirect_valid});
    endtask

    // Advance the model by one clock edge using the inputs applied this cycle.
    task automatic modelStep();
        logic [31:0] target;
        target = redirect_pc & ~32'd3;
        if (rst) begin
            modelValid = 1;
            mBusy = 0; mReq = 0; mHeld = 0; mDoomed = 0;
            mWord = 0; mPc = 0;
            mResume = MODEL_RESET_PC;
            mAddr = MODEL_RESET_PC;
        end else if (!modelValid) begin
            // Nothing known before the first reset.
        end else if (!mBusy) begin
            mBusy = 1;
            mReq = 1;
            mAddr = redirect_valid ? target : mResume;
        end else if (mReq) begin
            if (redirect_valid) begin
                mResume = target;
                if (mem_ack) begin
                    mAddr = target;
                    mDoomed = 0;
                end else begin
                    mDoomed = 1;
                end
            end else if (mem_ack) begin
                if (mDoomed) begin
                    mDoomed = 0;
                    mAddr = mResume;
                end else begin
                    mReq = 0;
                    mHeld = 1;
                    mWord = mem_rdata;
                    mPc = mAddr;
                end
            end
        end else if (mHeld) begin
            if (redirect_valid) begin
                mHeld = 0; mReq = 1;
                mAddr = target; mResume = target;
            end else if (!stall) begin
                mHeld = 0; mReq = 1;
                mAddr = mPc + 32'd4; mResume = mPc + 32'd4;
            end
        end
    endtask

    // Drive one cycle of inputs, check, snapshot, step the model, clock.
    task automatic applyStimulus(input bit rstV, input bit stallV, input bit rvV,
                                 input logic [31:0] rpcV, input bit ackV);
        rst = rstV;
        stall = stallV;
        redirect_valid = rvV;
        redirect_pc = rpcV;
        mem_ack = ackV;
        mem_rdata = mem_addr ^ DATA_KEY;
        mem_rdata2 = mem_addr2 ^ DATA_KEY;
        #1;
        if (modelValid) compareModel();
        if (cyc < 64) begin
            snapReq[cyc] = mem_req;
            snapIr[cyc] = ir_enable;
            snapIr2[cyc] = ir_enable2;
            snapAddr[cyc] = mem_addr;
            snapAddr2[cyc] = mem_addr2;
            snapPc[cyc] = pc_out;
            snapPc2[cyc] = pc_out2;
            snapInstr[cyc] = instr_out;
        end
        cyc++;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0);
        cyc = 0;
    endtask

    function automatic int countIr(input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) if (snapIr[i]) n++;
        return n;
    endfunction

    initial begin
        rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
        mem_ack = 0; mem_rdata = 0; mem_rdata2 = 0; cyc = 0;
        @(posedge clk);
        #1;

        // Zero-wait memory: pulses every second cycle, wrap on the second unit.
        doReset();
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset instr_out", instr_out, 32'h0);
        checkOutput("reset pc_out", pc_out, 32'h0);
        for (int c = 0; c < 9; c++) applyStimulus(0, 0, 0, 32'h0, 1);
        checkOutput("first pulse timing", {31'b0, snapIr[2]}, 32'd1);
        checkOutput("pulses in zero-wait run", countIr(0, 8), 32'd4);
        checkOutput("zw pc_out #1", snapPc[2], 32'h0);
        checkOutput("zw pc_out #2", snapPc[4], 32'h4);
        checkOutput("zw pc_out #3", snapPc[6], 32'h8);
        checkOutput("zw pc_out #4", snapPc[8], 32'hC);
        checkOutput("zw instr_out #4", snapInstr[8], 32'hA5A5_000C);
        checkOutput("wrap pc_out #1", snapIr2[2] ? snapPc2[2] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        checkOutput("wrap pc_out #2", snapIr2[4] ? snapPc2[4] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        checkOutput("wrap pc_out #3", snapIr2[6] ? snapPc2[6] : 32'hDEAD_BEEF, 32'h0000_0000);

        // Ack delayed three cycles on address 4.
        doReset();
        for (int c = 0; c < 8; c++) applyStimulus(0, 0, 0, 32'h0, !(c >= 3 && c <= 5));
        begin
            int held = 0;
            for (int i = 3; i <= 6; i++) if (snapReq[i] && snapAddr[i] == 32'h4) held++;
            checkOutput("req held on addr 4", held, 32'd4);
        end
        checkOutput("pulses with wait", countIr(0, 7), 32'd2);
        checkOutput("delayed pc_out", snapIr[7] ? snapPc[7] : 32'hDEAD_BEEF, 32'h4);

        // Stall for five cycles while address 8 is held.
        doReset();
        for (int c = 0; c < 13; c++) applyStimulus(0, c >= 6 && c <= 10, 0, 32'h0, 1);
        checkOutput("no pulse while stalled", countIr(6, 10), 32'd0);
        checkOutput("stalled pc_out", snapPc[10], 32'h8);
        checkOutput("stalled instr_out", snapInstr[10], 32'hA5A5_0008);
        checkOutput("release pulse", snapIr[11] ? snapPc[11] : 32'hDEAD_BEEF, 32'h8);
        checkOutput("after stall mem_addr", snapReq[12] ? snapAddr[12] : 32'hDEAD_BEEF, 32'hC);

        // Redirect while waiting on address 4; the late ack is discarded.
        doReset();
        for (int c = 0; c < 8; c++) applyStimulus(0, 0, c == 3, 32'h1003, !(c == 3 || c == 4));
        checkOutput("no pulse for killed word", countIr(3, 6), 32'd0);
        checkOutput("refetch mem_addr", snapReq[6] ? snapAddr[6] : 32'hDEAD_BEEF, 32'h1000);
        checkOutput("redirected pc_out", snapIr[7] ? snapPc[7] : 32'hDEAD_BEEF, 32'h1000);
        checkOutput("redirected instr_out", snapInstr[7], 32'hA5A5_1000);

        // Redirect coincident with ack, then redirect plus stall in DELIVER.
        doReset();
        for (int c = 0; c < 8; c++)
            applyStimulus(0, c == 5, c == 1 || c == 5, (c == 1) ? 32'h3000 : 32'h2000, 1);
        checkOutput("ack+redirect no pulse", {31'b0, snapIr[2]}, 32'd0);
        checkOutput("ack+redirect mem_addr", snapReq[2] ? snapAddr[2] : 32'hDEAD_BEEF, 32'h3000);
        checkOutput("ack+redirect pc_out", snapIr[3] ? snapPc[3] : 32'hDEAD_BEEF, 32'h3000);
        checkOutput("deliver redirect no pulse", {31'b0, snapIr[5]}, 32'd0);
        checkOutput("deliver redirect mem_addr", snapReq[6] ? snapAddr[6] : 32'hDEAD_BEEF, 32'h2000);
        checkOutput("deliver redirect pc_out", snapIr[7] ? snapPc[7] : 32'hDEAD_BEEF, 32'h2000);

        // Reset asserted in the middle of a pending request.
        doReset();
        for (int c = 0; c < 7; c++) applyStimulus(c == 4, 0, 0, 32'h0, c != 3 && c != 4);
        checkOutput("req before reset", {31'b0, snapReq[4]}, 32'd1);
        checkOutput("req dropped after reset", {31'b0, snapReq[5]}, 32'd0);
        checkOutput("restart mem_addr", snapReq[6] ? snapAddr[6] : 32'hDEAD_BEEF, 32'h0);
        checkOutput("restart wrap mem_addr", snapAddr2[6], 32'hFFFF_FFF8);

        // Randomized traffic checked cycle by cycle against the model.
        for (int c = 0; c < 4000; c++) begin
            applyStimulus($urandom_range(0, 255) == 0,
                          $urandom_range(0, 2) == 0,
                          $urandom_range(0, 11) == 0,
                          $urandom,
                          $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream feeder for the 32-bit Intermediate_Register pipeline stage. Holds the program counter and fetches one 32-bit word per request from instruction memory using a req/ack handshake. Presents each fetched word on instr_out with a one-cycle ir_enable strobe that drives the register's enable input directly. Supports stall from downstream and PC redirect (branch/jump).

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0
PC_STEP, 4, increment applied to PC after each delivered word

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
stall  in  1  downstream not ready; holds the delivered word
redirect_valid  in  1  load redirect_pc as next fetch address
redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0)
mem_req  out  1  memory request valid
mem_addr  out  32  request address, word aligned
mem_ack  in  1  memory accepts request; mem_rdata valid this cycle
mem_rdata  in  32  fetched word
instr_out  out  32  word to Intermediate_Register data_in
ir_enable  out  1  load strobe to Intermediate_Register enable
pc_out  out  32  address of word on instr_out
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=1 at edge): state=IDLE, pc=RESET_PC, req_addr=RESET_PC, kill=0, instr_buf=0, pc_out=0. Outputs: mem_req=0, ir_enable=0, instr_out=0, busy=0. Reset overrides everything, including an outstanding handshake, so mem_req drops the next cycle. The memory model must tolerate an abandoned request.
- States: IDLE, REQ, DELIVER.
- IDLE: unconditional move to REQ next cycle. req_addr<=pc, or redirect_pc&~3 if redirect_valid.
- REQ:
  - mem_req=1, mem_addr=req_addr, held stable until mem_ack.
  - Ack is sampled at the edge where mem_req=1 and mem_ack=1; zero-wait ack in the first REQ cycle is legal.
  - On ack with kill=0: instr_buf<=mem_rdata, pc_out<=req_addr, go DELIVER.
  - On ack with kill=1: discard data, clear kill, req_addr<=pc, stay REQ.
  - redirect_valid in REQ: pc<=redirect_pc&~3. If no ack this cycle, set kill=1. If ack this cycle, treat it as kill (discard) and req_addr<=new pc.
- DELIVER:
  - instr_out=instr_buf.
  - ir_enable = (state==DELIVER) && !stall && !redirect_valid (combinational).
  - stall=1: hold state, instr_out and pc_out stable, ir_enable=0.
  - Not stalled: ir_enable=1 for exactly this cycle; pc<=pc_out+PC_STEP; req_addr<=pc_out+PC_STEP; go REQ.
  - redirect_valid (priority over stall): word dropped, ir_enable=0, pc<=req_addr<=redirect_pc&~3, go REQ.
- Arithmetic: 32-bit modulo. 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- Throughput: one word per 2 cycles with zero-wait memory. Latency from rst deassert: IDLE one cycle, REQ next, ir_enable the following cycle.
- mem_req is never high in IDLE or DELIVER. Exactly one ir_enable pulse per accepted, non-killed ack.
- instr_out holds its last value outside DELIVER; it is not cleared.

Test Plan:
- Reset then zero-wait memory returning mem_rdata=addr^32'hA5A5_0000 -> ir_enable pulses every 2nd cycle; pc_out sequence 0,4,8,C; instr_out matches; first pulse 2 cycles after IDLE; Intermediate_Register data_out follows.
- mem_ack delayed 3 cycles on addr 4 -> mem_addr stays 32'h4 and mem_req stays 1 for 4 cycles; a single ir_enable with pc_out=4.
- stall=1 for 5 cycles during DELIVER of addr 8 -> ir_enable=0 and instr_out/pc_out frozen; one pulse on stall release; next mem_addr=C.
- redirect_valid with redirect_pc=32'h1003 while REQ waits on addr 4 (ack 2 cycles later) -> late ack discarded; next mem_addr=32'h1000; first delivered pc_out=32'h1000; no pulse for addr 4.
- redirect in DELIVER together with stall=1 -> no ir_enable; next mem_addr=redirect target; redirect_valid coincident with ack -> data discarded.
- RESET_PC=32'hFFFF_FFF8 -> deliveries at FFFF_FFF8, FFFF_FFFC, 0000_0000. rst asserted mid-REQ -> mem_req=0 next cycle, restart at RESET_PC.
